id_ex_stage: RTL and testbench
==============================

# id_ex_stage

ID/EX pipeline register that feeds the `alu` in the execute stage. It captures decoded operands and control from decode each cycle, and applies EX/MEM and MEM/WB forwarding on its operand outputs. It supports hold (stall) and bubble insertion (flush), and flags load-use hazards back to the hazard unit. All `alu` operand inputs (`a_i_data_rs`, `a_i_data_rt`, `a_i_imm`, `a_i_funct`, `a_i_alu_src`, `a_i_pc`) are driven directly from this block.

## Interface
Parameters (macros from the shared header):
- `DWIDTH`, default 32: data width.
- `IMM_WIDTH`, default 16: immediate width.
- `PC_WIDTH`, default 32: PC width.

Ports:
- `ie_i_clk` in 1: single clock, rising edge.
- `ie_i_rst_n` in 1: reset, synchronous, active-low.
- `ie_i_valid` in 1: decode presents a valid instruction.
- `ie_i_data_rs`, `ie_i_data_rt` in DWIDTH: register-file read data.
- `ie_i_rs`, `ie_i_rt`, `ie_i_rd` in 5: source and destination register numbers.
- `ie_i_imm` in IMM_WIDTH: immediate.
- `ie_i_funct` in 5: ALU operation.
- `ie_i_alu_src` in 1: 1 selects the immediate as the ALU B operand.
- `ie_i_pc` in PC_WIDTH: instruction PC.
- `ie_i_reg_write`, `ie_i_mem_read`, `ie_i_mem_write`, `ie_i_mem_to_reg` in 1: downstream control.
- `ie_i_stall` in 1: hold the EX contents.
- `ie_i_flush` in 1: replace the next EX contents with a bubble.
- `ie_i_em_reg_write` in 1, `ie_i_em_rd` in 5, `ie_i_em_value` in DWIDTH: EX/MEM forwarding source.
- `ie_i_mw_reg_write` in 1, `ie_i_mw_rd` in 5, `ie_i_mw_value` in DWIDTH: MEM/WB forwarding source.
- `ie_o_valid` out 1: EX holds a valid instruction.
- `ie_o_data_rs`, `ie_o_data_rt` out DWIDTH: forwarded operands, connected to the ALU.
- `ie_o_imm` out IMM_WIDTH, `ie_o_funct` out 5, `ie_o_alu_src` out 1, `ie_o_pc` out PC_WIDTH: passed to the ALU.
- `ie_o_rd` out 5; `ie_o_reg_write`, `ie_o_mem_read`, `ie_o_mem_write`, `ie_o_mem_to_reg` out 1: passed to EX/MEM.
- `ie_o_load_use` out 1: combinational load-use hazard flag to the hazard unit.

## Operation
- **Load**: when neither `ie_i_stall` nor `ie_i_flush` is asserted, every `ie_i_*` decode field is registered on the clock edge.
- **Flush**:
  - `ie_i_flush` loads a bubble: valid=0, reg_write=0, mem_read=0, mem_write=0, mem_to_reg=0, funct=0, rd=0, data=0.
  - Flush has priority over stall.
- **Stall**:
  - Addresses and control hold their values.
  - The rs/rt data registers reload with the current forwarded values (`ie_o_data_rs`/`ie_o_data_rt`). A producer that retires during the stall is therefore not lost.
- **Forwarding** is applied per operand, combinationally from the registered register number:
  - EX/MEM wins if `em_reg_write` is set, `em_rd` equals the register number, and the register number is not 0.
  - Otherwise MEM/WB wins under the same conditions using `mw_*`.
  - Otherwise the registered value is used.
  - `$0` is never forwarded.
- **Load-use flag**: `ie_o_load_use` = `ie_o_valid` & `ie_o_mem_read` & (`ie_o_rd` ≠ 0) & (`ie_o_rd` == `ie_i_rs` | `ie_o_rd` == `ie_i_rt`). The hazard unit uses it to stall decode and flush this stage.
- Forwarding is applied regardless of `ie_o_valid`; a bubble carries no side effects because all its write enables are 0.

## Timing
- Latency is 1 cycle from decode inputs to registered outputs.
- Forwarding adds combinational delay in front of the ALU; its outputs reflect the `em`/`mw` inputs in the same cycle.
- **Reset**: `ie_i_rst_n` low at a rising edge clears all registered outputs to 0 (valid=0, all controls 0).
  - Reset overrides stall and flush.
  - A reset mid-stall discards the held instruction.
- Stall and flush asserted in the same cycle give a bubble.
- Stall held for N cycles keeps the same instruction for N cycles. Its operands keep updating from the forwarding paths, so the final value is the latest one forwarded.
- `ie_o_load_use` is purely combinational, with no registered delay.

## Structure
- `DWIDTH`, `IMM_WIDTH`, `PC_WIDTH`, and register-number width 5 stay in the shared header used by `alu`.
- Bubble field values are defined as named constants in that header.
- One sub-module: `fwd_mux`, a per-operand forwarding selector instantiated twice (rs, rt).
- The pipeline register stays in `id_ex_stage`.

## Test plan
- **Reset then load**: hold reset low for 2 cycles → all outputs 0. Then load rs=5, rt=4, funct=0, pc=10 → next cycle outputs 5, 4, 0, 10, valid=1.
- **EX/MEM forward**: registered rs=3 with data 7; `em_reg_write`=1, `em_rd`=3, `em_value`=99 → `ie_o_data_rs`=99. Repeat with rs=0 → data unchanged (no forward).
- **Priority**: `em_rd`=`mw_rd`=4, `em_value`=11, `mw_value`=22, both write enables 1 → operand=11. Clear `em_reg_write` → operand=22.
- **Stall with forward capture**: stall 2 cycles; cycle 1 MEM/WB forwards 33 to rt, cycle 2 no forward → `ie_o_data_rt` stays 33 and the other fields are unchanged.
- **Flush vs stall**: assert both together → next cycle valid=0, reg_write=0, funct=0.
- **Load-use**: EX holds mem_read=1, rd=8; decode presents rt=8 → `ie_o_load_use`=1. With rd=0 → 0.

Source files
------------

// File: rtl/id_ex_stage_pkg.sv
// Shared widths, EX register layout and bubble constants for the ID/EX stage
// and the execute-stage alu.
//   DWIDTH / IMM_WIDTH / PC_WIDTH / RWIDTH : datapath, immediate, PC, regnum widths
//   ex_regs_t  : contents of the ID/EX pipeline register
//   EX_BUBBLE  : value loaded on flush (no valid, no write enables, zero fields)
//   fwd_hit()  : forwarding match test shared by both operand selectors
package id_ex_stage_pkg;

    localparam int DWIDTH    = 32;
    localparam int IMM_WIDTH = 16;
    localparam int PC_WIDTH  = 32;
    localparam int RWIDTH    = 5;

    typedef struct packed {
        logic                 valid;
        logic [RWIDTH-1:0]    rs;
        logic [RWIDTH-1:0]    rt;
        logic [RWIDTH-1:0]    rd;
        logic [DWIDTH-1:0]    data_rs;
        logic [DWIDTH-1:0]    data_rt;
        logic [IMM_WIDTH-1:0] imm;
        logic [4:0]           funct;
        logic                 alu_src;
        logic [PC_WIDTH-1:0]  pc;
        logic                 reg_write;
        logic                 mem_read;
        logic                 mem_write;
        logic                 mem_to_reg;
    } ex_regs_t;

    // Bubble: every field zero. Clearing rs/rt too keeps a bubble from
    // picking up forwarded data on its operand outputs.
    localparam logic              BUBBLE_VALID = 1'b0;
    localparam logic              BUBBLE_CTRL  = 1'b0;
    localparam logic [4:0]        BUBBLE_FUNCT = 5'd0;
    localparam logic [RWIDTH-1:0] BUBBLE_RD    = '0;
    localparam logic [DWIDTH-1:0] BUBBLE_DATA  = '0;
    localparam ex_regs_t          EX_BUBBLE    = '0;

    // $0 is hardwired zero, so it never matches a producer.
    function automatic logic fwd_hit(input logic              we,
                                     input logic [RWIDTH-1:0] src_rd,
                                     input logic [RWIDTH-1:0] reg_num);
        return we && (src_rd == reg_num) && (reg_num != '0);
    endfunction

endpackage

// File: rtl/id_ex_stage_fwd_mux.sv
// Per-operand forwarding selector: EX/MEM beats MEM/WB beats the
// registered register-file value.
//   reg_i / data_i          : registered register number and its data
//   em_we_i/em_rd_i/em_val_i: EX/MEM producer
//   mw_we_i/mw_rd_i/mw_val_i: MEM/WB producer
//   data_o                  : forwarded operand
module fwd_mux
    import id_ex_stage_pkg::*;
(
    input  logic [RWIDTH-1:0] reg_i,
    input  logic [DWIDTH-1:0] data_i,
    input  logic              em_we_i,
    input  logic [RWIDTH-1:0] em_rd_i,
    input  logic [DWIDTH-1:0] em_val_i,
    input  logic              mw_we_i,
    input  logic [RWIDTH-1:0] mw_rd_i,
    input  logic [DWIDTH-1:0] mw_val_i,
    output logic [DWIDTH-1:0] data_o
);

    always_comb begin
        data_o = data_i;
        if (fwd_hit(em_we_i, em_rd_i, reg_i))
            data_o = em_val_i;
        else if (fwd_hit(mw_we_i, mw_rd_i, reg_i))
            data_o = mw_val_i;
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register in front of the alu, with EX/MEM and MEM/WB
// operand forwarding, stall/flush control and a load-use hazard flag.
//   ie_i_*            : decode fields, stall/flush, forwarding sources
//   ie_o_valid        : EX holds a valid instruction
//   ie_o_data_rs/rt   : forwarded operands to the alu
//   ie_o_imm/funct/alu_src/pc : alu controls
//   ie_o_rd + controls: passed to EX/MEM
//   ie_o_load_use     : combinational load-use hazard flag
module id_ex_stage
    import id_ex_stage_pkg::*;
(
    input  logic                 ie_i_clk,
    input  logic                 ie_i_rst_n,
    input  logic                 ie_i_valid,
    input  logic [DWIDTH-1:0]    ie_i_data_rs,
    input  logic [DWIDTH-1:0]    ie_i_data_rt,
    input  logic [RWIDTH-1:0]    ie_i_rs,
    input  logic [RWIDTH-1:0]    ie_i_rt,
    input  logic [RWIDTH-1:0]    ie_i_rd,
    input  logic [IMM_WIDTH-1:0] ie_i_imm,
    input  logic [4:0]           ie_i_funct,
    input  logic                 ie_i_alu_src,
    input  logic [PC_WIDTH-1:0]  ie_i_pc,
    input  logic                 ie_i_reg_write,
    input  logic                 ie_i_mem_read,
    input  logic                 ie_i_mem_write,
    input  logic                 ie_i_mem_to_reg,
    input  logic                 ie_i_stall,
    input  logic                 ie_i_flush,
    input  logic                 ie_i_em_reg_write,
    input  logic [RWIDTH-1:0]    ie_i_em_rd,
    input  logic [DWIDTH-1:0]    ie_i_em_value,
    input  logic                 ie_i_mw_reg_write,
    input  logic [RWIDTH-1:0]    ie_i_mw_rd,
    input  logic [DWIDTH-1:0]    ie_i_mw_value,
    output logic                 ie_o_valid,
    output logic [DWIDTH-1:0]    ie_o_data_rs,
    output logic [DWIDTH-1:0]    ie_o_data_rt,
    output logic [IMM_WIDTH-1:0] ie_o_imm,
    output logic [4:0]           ie_o_funct,
    output logic                 ie_o_alu_src,
    output logic [PC_WIDTH-1:0]  ie_o_pc,
    output logic [RWIDTH-1:0]    ie_o_rd,
    output logic                 ie_o_reg_write,
    output logic                 ie_o_mem_read,
    output logic                 ie_o_mem_write,
    output logic                 ie_o_mem_to_reg,
    output logic                 ie_o_load_use
);

    ex_regs_t ex_q, ex_d;

    fwd_mux u_fwd_rs (
        .reg_i    (ex_q.rs),
        .data_i   (ex_q.data_rs),
        .em_we_i  (ie_i_em_reg_write),
        .em_rd_i  (ie_i_em_rd),
        .em_val_i (ie_i_em_value),
        .mw_we_i  (ie_i_mw_reg_write),
        .mw_rd_i  (ie_i_mw_rd),
        .mw_val_i (ie_i_mw_value),
        .data_o   (ie_o_data_rs)
    );

    fwd_mux u_fwd_rt (
        .reg_i    (ex_q.rt),
        .data_i   (ex_q.data_rt),
        .em_we_i  (ie_i_em_reg_write),
        .em_rd_i  (ie_i_em_rd),
        .em_val_i (ie_i_em_value),
        .mw_we_i  (ie_i_mw_reg_write),
        .mw_rd_i  (ie_i_mw_rd),
        .mw_val_i (ie_i_mw_value),
        .data_o   (ie_o_data_rt)
    );

    always_comb begin
        // Stall default: hold everything but recapture the forwarded operands
        // so a producer retiring during the stall is not lost.
        ex_d         = ex_q;
        ex_d.data_rs = ie_o_data_rs;
        ex_d.data_rt = ie_o_data_rt;
        if (ie_i_flush) begin
            ex_d = EX_BUBBLE;
        end else if (!ie_i_stall) begin
            ex_d.valid      = ie_i_valid;
            ex_d.rs         = ie_i_rs;
            ex_d.rt         = ie_i_rt;
            ex_d.rd         = ie_i_rd;
            ex_d.data_rs    = ie_i_data_rs;
            ex_d.data_rt    = ie_i_data_rt;
            ex_d.imm        = ie_i_imm;
            ex_d.funct      = ie_i_funct;
            ex_d.alu_src    = ie_i_alu_src;
            ex_d.pc         = ie_i_pc;
            ex_d.reg_write  = ie_i_reg_write;
            ex_d.mem_read   = ie_i_mem_read;
            ex_d.mem_write  = ie_i_mem_write;
            ex_d.mem_to_reg = ie_i_mem_to_reg;
        end
    end

    always_ff @(posedge ie_i_clk) begin
        if (!ie_i_rst_n)
            ex_q <= '0;
        else
            ex_q <= ex_d;
    end

    assign ie_o_valid      = ex_q.valid;
    assign ie_o_imm        = ex_q.imm;
    assign ie_o_funct      = ex_q.funct;
    assign ie_o_alu_src    = ex_q.alu_src;
    assign ie_o_pc         = ex_q.pc;
    assign ie_o_rd         = ex_q.rd;
    assign ie_o_reg_write  = ex_q.reg_write;
    assign ie_o_mem_read   = ex_q.mem_read;
    assign ie_o_mem_write  = ex_q.mem_write;
    assign ie_o_mem_to_reg = ex_q.mem_to_reg;

    assign ie_o_load_use = ex_q.valid && ex_q.mem_read && (ex_q.rd != '0) &&
                           ((ex_q.rd == ie_i_rs) || (ex_q.rd == ie_i_rt));

endmodule

// File: tb/tb_id_ex_stage.sv
module tb_id_ex_stage;
    import id_ex_stage_pkg::*;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 i_valid, i_alu_src, i_rw, i_mr, i_mw, i_m2r, stall, flush;
    logic [DWIDTH-1:0]    i_drs, i_drt, em_val, mw_val;
    logic [RWIDTH-1:0]    i_rs, i_rt, i_rd, em_rd, mw_rd;
    logic [IMM_WIDTH-1:0] i_imm;
    logic [4:0]           i_funct;
    logic [PC_WIDTH-1:0]  i_pc;
    logic                 em_we, mw_we;
    logic                 o_valid, o_alu_src, o_rw, o_mr, o_mw, o_m2r, o_lu;
    logic [DWIDTH-1:0]    o_drs, o_drt;
    logic [IMM_WIDTH-1:0] o_imm;
    logic [4:0]           o_funct;
    logic [PC_WIDTH-1:0]  o_pc;
    logic [RWIDTH-1:0]    o_rd;

    always #5 clk = ~clk;

    id_ex_stage dut (
        .ie_i_clk(clk), .ie_i_rst_n(rst_n), .ie_i_valid(i_valid),
        .ie_i_data_rs(i_drs), .ie_i_data_rt(i_drt),
        .ie_i_rs(i_rs), .ie_i_rt(i_rt), .ie_i_rd(i_rd),
        .ie_i_imm(i_imm), .ie_i_funct(i_funct), .ie_i_alu_src(i_alu_src), .ie_i_pc(i_pc),
        .ie_i_reg_write(i_rw), .ie_i_mem_read(i_mr), .ie_i_mem_write(i_mw),
        .ie_i_mem_to_reg(i_m2r), .ie_i_stall(stall), .ie_i_flush(flush),
        .ie_i_em_reg_write(em_we), .ie_i_em_rd(em_rd), .ie_i_em_value(em_val),
        .ie_i_mw_reg_write(mw_we), .ie_i_mw_rd(mw_rd), .ie_i_mw_value(mw_val),
        .ie_o_valid(o_valid), .ie_o_data_rs(o_drs), .ie_o_data_rt(o_drt),
        .ie_o_imm(o_imm), .ie_o_funct(o_funct), .ie_o_alu_src(o_alu_src), .ie_o_pc(o_pc),
        .ie_o_rd(o_rd), .ie_o_reg_write(o_rw), .ie_o_mem_read(o_mr),
        .ie_o_mem_write(o_mw), .ie_o_mem_to_reg(o_m2r), .ie_o_load_use(o_lu)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    typedef struct {
        logic        valid;
        logic [31:0] drs, drt, pc;
        logic [4:0]  funct, rd;
        logic        rw, mr;
        bit          chk_pc;
        string       tag;
    } exp_t;

    exp_t sb[$];

    task automatic push(input string tag, input logic v, input logic [31:0] drs, drt,
                        input logic [4:0] funct, rd, input logic [31:0] pc,
                        input logic rw, mr, input bit cpc);
        exp_t e;
        e.tag = tag; e.valid = v; e.drs = drs; e.drt = drt; e.funct = funct;
        e.rd = rd; e.pc = pc; e.rw = rw; e.mr = mr; e.chk_pc = cpc;
        sb.push_back(e);
    endtask

    task automatic pop_check();
        exp_t e;
        if (sb.size() == 0) begin
            chk("sb_empty", 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            chk({e.tag, ".valid"}, {31'd0, o_valid}, {31'd0, e.valid});
            chk({e.tag, ".drs"}, o_drs, e.drs);
            chk({e.tag, ".drt"}, o_drt, e.drt);
            chk({e.tag, ".funct"}, {27'd0, o_funct}, {27'd0, e.funct});
            chk({e.tag, ".rd"}, {27'd0, o_rd}, {27'd0, e.rd});
            chk({e.tag, ".rw"}, {31'd0, o_rw}, {31'd0, e.rw});
            chk({e.tag, ".mr"}, {31'd0, o_mr}, {31'd0, e.mr});
            if (e.chk_pc) chk({e.tag, ".pc"}, o_pc, e.pc);
        end
    endtask

    // Advance one clock; sample 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [4:0] rs, rt, rd,
                         input logic [31:0] drs, drt, input logic [4:0] funct,
                         input logic [31:0] pc, input logic rw, mr);
        i_valid = v; i_rs = rs; i_rt = rt; i_rd = rd; i_drs = drs; i_drt = drt;
        i_funct = funct; i_pc = pc; i_rw = rw; i_mr = mr;
    endtask

    initial begin
        rst_n = 1'b0; stall = 1'b0; flush = 1'b0;
        i_imm = '0; i_alu_src = 1'b0; i_mw = 1'b0; i_m2r = 1'b0;
        em_we = 1'b0; em_rd = '0; em_val = '0;
        mw_we = 1'b0; mw_rd = '0; mw_val = '0;
        drive(1'b1, 5'd9, 5'd9, 5'd9, 32'd77, 32'd88, 5'd7, 32'd100, 1'b1, 1'b1);

        // Reset for two cycles, with garbage on the decode inputs.
        push("rst", 1'b0, 0, 0, 0, 0, 0, 1'b0, 1'b0, 1'b1);
        step(); step();
        pop_check();
        chk("rst.load_use", {31'd0, o_lu}, 32'd0);

        // Plain load.
        rst_n = 1'b1;
        drive(1'b1, 5'd3, 5'd6, 5'd2, 32'd5, 32'd4, 5'd0, 32'd10, 1'b1, 1'b0);
        push("load", 1'b1, 32'd5, 32'd4, 5'd0, 5'd2, 32'd10, 1'b1, 1'b0, 1'b1);
        step(); pop_check();

        // EX/MEM forward onto rs=3.
        drive(1'b1, 5'd3, 5'd4, 5'd2, 32'd7, 32'd8, 5'd3, 32'd14, 1'b1, 1'b0);
        push("ld_em", 1'b1, 32'd7, 32'd8, 5'd3, 5'd2, 32'd14, 1'b1, 1'b0, 1'b1);
        step(); pop_check();
        em_we = 1'b1; em_rd = 5'd3; em_val = 32'd99;
        #1;
        chk("fwd_em.rs", o_drs, 32'd99);
        chk("fwd_em.rt_untouched", o_drt, 32'd8);

        // rs=0 is never forwarded, even when the producer targets $0.
        em_rd = 5'd0;
        drive(1'b1, 5'd0, 5'd4, 5'd2, 32'd7, 32'd8, 5'd3, 32'd18, 1'b1, 1'b0);
        push("fwd_r0", 1'b1, 32'd7, 32'd8, 5'd3, 5'd2, 32'd18, 1'b1, 1'b0, 1'b1);
        step(); pop_check();
        em_we = 1'b0;

        // Priority: EX/MEM over MEM/WB.
        drive(1'b1, 5'd4, 5'd9, 5'd2, 32'd1, 32'd2, 5'd1, 32'd22, 1'b1, 1'b0);
        push("ld_prio", 1'b1, 32'd1, 32'd2, 5'd1, 5'd2, 32'd22, 1'b1, 1'b0, 1'b1);
        step(); pop_check();
        em_we = 1'b1; em_rd = 5'd4; em_val = 32'd11;
        mw_we = 1'b1; mw_rd = 5'd4; mw_val = 32'd22;
        #1;
        chk("prio.em", o_drs, 32'd11);
        em_we = 1'b0;
        #1;
        chk("prio.mw", o_drs, 32'd22);
        mw_we = 1'b0;
        #1;
        chk("prio.none", o_drs, 32'd1);

        // Stall two cycles: MEM/WB forwards 33 to rt in the first, nothing in the second.
        drive(1'b1, 5'd1, 5'd7, 5'd12, 32'd50, 32'd60, 5'd5, 32'd20, 1'b1, 1'b0);
        push("ld_stall", 1'b1, 32'd50, 32'd60, 5'd5, 5'd12, 32'd20, 1'b1, 1'b0, 1'b1);
        step(); pop_check();
        stall = 1'b1;
        drive(1'b1, 5'd2, 5'd3, 5'd4, 32'd999, 32'd999, 5'd9, 32'd44, 1'b0, 1'b1);
        mw_we = 1'b1; mw_rd = 5'd7; mw_val = 32'd33;
        push("stall1", 1'b1, 32'd50, 32'd33, 5'd5, 5'd12, 32'd20, 1'b1, 1'b0, 1'b1);
        step(); pop_check();
        mw_we = 1'b0;
        push("stall2", 1'b1, 32'd50, 32'd33, 5'd5, 5'd12, 32'd20, 1'b1, 1'b0, 1'b1);
        step(); pop_check();

        // Flush together with stall gives a bubble.
        flush = 1'b1;
        push("flush", 1'b0, 0, 0, 5'd0, 5'd0, 0, 1'b0, 1'b0, 1'b0);
        step(); pop_check();
        stall = 1'b0; flush = 1'b0;

        // Load-use: EX holds a load to r8.
        drive(1'b1, 5'd1, 5'd2, 5'd8, 32'd3, 32'd4, 5'd2, 32'd30, 1'b1, 1'b1);
        push("ld_lu", 1'b1, 32'd3, 32'd4, 5'd2, 5'd8, 32'd30, 1'b1, 1'b1, 1'b1);
        step(); pop_check();
        i_rs = 5'd1; i_rt = 5'd8;
        #1;
        chk("lu.rt_hit", {31'd0, o_lu}, 32'd1);
        i_rs = 5'd8; i_rt = 5'd2;
        #1;
        chk("lu.rs_hit", {31'd0, o_lu}, 32'd1);
        i_rs = 5'd1; i_rt = 5'd2;
        #1;
        chk("lu.miss", {31'd0, o_lu}, 32'd0);

        // Load to $0 never raises the flag.
        drive(1'b1, 5'd1, 5'd2, 5'd0, 32'd3, 32'd4, 5'd2, 32'd34, 1'b1, 1'b1);
        push("ld_lu0", 1'b1, 32'd3, 32'd4, 5'd2, 5'd0, 32'd34, 1'b1, 1'b1, 1'b1);
        step(); pop_check();
        i_rs = 5'd0; i_rt = 5'd0;
        #1;
        chk("lu.rd0", {31'd0, o_lu}, 32'd0);

        // Reset during a stall discards the held instruction.
        drive(1'b1, 5'd5, 5'd6, 5'd7, 32'd15, 32'd16, 5'd4, 32'd40, 1'b1, 1'b0);
        push("ld_pre_rst", 1'b1, 32'd15, 32'd16, 5'd4, 5'd7, 32'd40, 1'b1, 1'b0, 1'b1);
        step(); pop_check();
        stall = 1'b1; rst_n = 1'b0;
        push("rst_stall", 1'b0, 0, 0, 5'd0, 5'd0, 0, 1'b0, 1'b0, 1'b1);
        step(); pop_check();
        stall = 1'b0; rst_n = 1'b1;

        if (sb.size() != 0) chk("sb_leftover", sb.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
